serial_bit_tx: RTL and testbench

- Parallel-in, serial-out transmitter that drives a single-bit line `q` as framed serial data.
- Each frame is one start bit (0), DATA_W data bits LSB-first, and one stop bit (1).
- Every bit is held for CLKS_PER_BIT clocks.
- It is the sending end for the lab's flip-flop/shift-register capture blocks, which sample `q` on `clk`. Upstream logic hands it words over a valid/ready handshake.

---
 rtl/serial_bit_tx_if.sv | 23 ++
 rtl/serial_bit_tx.sv | 156 +++++++++++++++
 tb/tb_serial_bit_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_tx_if
// Purpose  : Valid/ready word handshake between upstream logic and the
//            serial_bit_tx transmitter.
// Signals  : data  - word offered by upstream (DATA_W bits)
//            valid - upstream has a word on data
//            ready - transmitter can accept a word this cycle
// Modports : master - upstream side (drives data/valid)
//            slave  - transmitter side (drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface serial_bit_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/serial_bit_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_tx
// Purpose  : Parallel-in, serial-out framed transmitter. Each accepted word
//            goes out as one start bit (0), DATA_W data bits LSB-first and
//            one stop bit (1), every bit held CLKS_PER_BIT clocks.
// Ports    : clk   - rising-edge clock
//            reset - synchronous active-low reset
//            bus   - slave side of the data/valid/ready handshake
//            q     - serial line, idles high
//            busy  - frame in progress
//            done  - one-cycle pulse when the stop bit completes
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  serial_bit_tx_if.slave    bus,
  output logic              q,
  output logic              busy,
  output logic              done
);

  // Counter widths never drop below one bit so CLKS_PER_BIT=1 / DATA_W=1
  // still produce legal vectors.
  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_bit_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state,  w_state;
  logic [c_baud_w-1:0] r_baud,   w_baud;
  logic [c_bit_w-1:0]  r_bitcnt, w_bitcnt;
  logic [DATA_W-1:0]   r_shreg,  w_shreg;
  logic                r_q,      w_q;
  logic                r_ready,  w_ready;
  logic                r_busy,   w_busy;
  logic                r_done,   w_done;

  logic                w_bit_end;
  logic [DATA_W-1:0]   w_shifted;

  assign w_bit_end = (r_baud == c_baud_last);
  // The next data bit is taken from the shifted word so no index past
  // DATA_W-1 is ever formed, even for DATA_W=1.
  assign w_shifted = r_shreg >> 1;

  always_comb begin
    w_state  = r_state;
    w_baud   = r_baud;
    w_bitcnt = r_bitcnt;
    w_shreg  = r_shreg;
    w_q      = r_q;
    w_ready  = r_ready;
    w_busy   = r_busy;
    w_done   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.valid && r_ready) begin
          w_state  = S_START;
          w_shreg  = bus.data;
          w_q      = 1'b0;
          w_ready  = 1'b0;
          w_busy   = 1'b1;
          w_baud   = '0;
          w_bitcnt = '0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state = S_DATA;
          w_q     = r_shreg[0];
          w_baud  = '0;
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud = '0;
          if (r_bitcnt == c_bit_last) begin
            w_state  = S_STOP;
            w_q      = 1'b1;
            w_bitcnt = '0;
          end else begin
            w_shreg  = w_shifted;
            w_q      = w_shifted[0];
            w_bitcnt = r_bitcnt + 1'b1;
          end
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          // ready returns together with done so a back-to-back word can be
          // accepted in the done cycle.
          w_state = S_IDLE;
          w_baud  = '0;
          w_ready = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_baud = r_baud + 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_q      <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_baud   <= w_baud;
      r_bitcnt <= w_bitcnt;
      r_shreg  <= w_shreg;
      r_q      <= w_q;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign bus.ready = r_ready;
  assign q         = r_q;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_tx
// Purpose  : Self-checking bench for serial_bit_tx. Two instances: default
//            parameters (8 data bits, 4 clocks/bit) and a fast variant
//            (5 data bits, 1 clock/bit). Expected line values come from the
//            frame rule: bit index i/CLKS selects start, data LSB-first, stop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_tx;

  localparam int A_W = 8;
  localparam int A_C = 4;
  localparam int B_W = 5;
  localparam int B_C = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic q_a, busy_a, done_a;
  logic q_b, busy_b, done_b;

  serial_bit_tx_if #(.DATA_W(A_W)) bus_a ();
  serial_bit_tx_if #(.DATA_W(B_W)) bus_b ();

  serial_bit_tx #(.DATA_W(A_W), .CLKS_PER_BIT(A_C)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .q     (q_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  serial_bit_tx #(.DATA_W(B_W), .CLKS_PER_BIT(B_C)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .q     (q_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Line value during cycle i of a frame (i = 0 is the first busy cycle).
  function automatic logic model_bit(input logic [31:0] w, input int dw,
                                     input int clks, input int i);
    int idx;
    idx = i / clks;
    if (idx == 0)
      return 1'b0;
    else if (idx <= dw)
      return w[idx-1];
    else
      return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_a_q"},     q_a,         1'b1);
    chk({tag, "_a_ready"}, bus_a.ready, 1'b1);
    chk({tag, "_a_busy"},  busy_a,      1'b0);
    chk({tag, "_a_done"},  done_a,      1'b0);
  endtask

  task automatic chk_idle_b(input string tag);
    chk({tag, "_b_q"},     q_b,         1'b1);
    chk({tag, "_b_ready"}, bus_b.ready, 1'b1);
    chk({tag, "_b_busy"},  busy_b,      1'b0);
    chk({tag, "_b_done"},  done_b,      1'b0);
  endtask

  task automatic idle_both(input int n);
    for (int i = 0; i < n; i++) begin
      chk_idle_a($sformatf("idle%0d", i));
      chk_idle_b($sformatf("idle%0d", i));
      step();
    end
  endtask

  // Starts at a cycle where ready is expected high. After the handshake,
  // valid/data are driven to nv/nd for the rest of the frame. Ends on the
  // done cycle when nv=1 (next word handshakes there), else one cycle later.
  task automatic frame_a(input logic [A_W-1:0] w, input logic nv,
                         input logic [A_W-1:0] nd);
    chk("a_ready_pre", bus_a.ready, 1'b1);
    bus_a.valid = 1'b1;
    bus_a.data  = w;
    step();
    bus_a.valid = nv;
    bus_a.data  = nd;
    for (int i = 0; i < (A_W + 2) * A_C; i++) begin
      chk($sformatf("a_q[%0d] w=%h", i, w), q_a, model_bit(32'(w), A_W, A_C, i));
      chk($sformatf("a_busy[%0d]", i),  busy_a,      1'b1);
      chk($sformatf("a_ready[%0d]", i), bus_a.ready, 1'b0);
      chk($sformatf("a_done[%0d]", i),  done_a,      1'b0);
      step();
    end
    chk("a_done_pulse", done_a,      1'b1);
    chk("a_done_busy",  busy_a,      1'b0);
    chk("a_done_ready", bus_a.ready, 1'b1);
    chk("a_done_q",     q_a,         1'b1);
    if (!nv) begin
      step();
      chk("a_done_gone", done_a, 1'b0);
    end
  endtask

  task automatic frame_b(input logic [B_W-1:0] w, input logic nv,
                         input logic [B_W-1:0] nd);
    chk("b_ready_pre", bus_b.ready, 1'b1);
    bus_b.valid = 1'b1;
    bus_b.data  = w;
    step();
    bus_b.valid = nv;
    bus_b.data  = nd;
    for (int i = 0; i < (B_W + 2) * B_C; i++) begin
      chk($sformatf("b_q[%0d] w=%h", i, w), q_b, model_bit(32'(w), B_W, B_C, i));
      chk($sformatf("b_busy[%0d]", i),  busy_b,      1'b1);
      chk($sformatf("b_ready[%0d]", i), bus_b.ready, 1'b0);
      chk($sformatf("b_done[%0d]", i),  done_b,      1'b0);
      step();
    end
    chk("b_done_pulse", done_b,      1'b1);
    chk("b_done_busy",  busy_b,      1'b0);
    chk("b_done_ready", bus_b.ready, 1'b1);
    chk("b_done_q",     q_b,         1'b1);
    if (!nv) begin
      step();
      chk("b_done_gone", done_b, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [A_W-1:0] w, nd;
    logic           nv;
    logic [B_W-1:0] wb, ndb;

    reset       = 1'b0;
    bus_a.valid = 1'b0;
    bus_a.data  = '0;
    bus_b.valid = 1'b0;
    bus_b.data  = '0;

    // Reset held low for three edges; outputs must be at idle values.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_a($sformatf("rst%0d", i));
      chk_idle_b($sformatf("rst%0d", i));
    end
    reset = 1'b1;
    idle_both(20);

    // Directed single frame.
    frame_a(8'hA5, 1'b0, 8'h00);
    idle_both(3);

    // valid held high: 00 then FF back-to-back, FF ignored during first frame.
    frame_a(8'h00, 1'b1, 8'hFF);
    frame_a(8'hFF, 1'b0, 8'h00);
    idle_both(2);

    // Data changes after handshake must not disturb the frame in flight.
    frame_a(8'hC3, 1'b0, 8'h3C);
    idle_both(2);

    // Reset in cycle 17 of a frame.
    w = 8'($urandom);
    bus_a.valid = 1'b1;
    bus_a.data  = w;
    step();
    bus_a.valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("rmid_q[%0d]", i), q_a, model_bit(32'(w), A_W, A_C, i));
      chk($sformatf("rmid_busy[%0d]", i), busy_a, 1'b1);
      if (i < 16) step();
    end
    reset = 1'b0;
    step();
    chk_idle_a("rmid_after");
    reset = 1'b1;
    for (int i = 0; i < 45; i++) begin
      chk($sformatf("rmid_nodone[%0d]", i), done_a, 1'b0);
      chk($sformatf("rmid_noq[%0d]", i),    q_a,    1'b1);
      step();
    end
    frame_a(8'($urandom), 1'b0, 8'($urandom));
    idle_both(1);

    // Simultaneous reset and valid: reset wins.
    bus_a.valid = 1'b1;
    bus_a.data  = 8'h5A;
    reset       = 1'b0;
    step();
    chk_idle_a("rst_valid");
    bus_a.valid = 1'b0;
    reset       = 1'b1;
    step();
    chk_idle_a("rst_valid_post");
    idle_both(2);

    // Randomised frames, some back-to-back with valid held.
    w = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      nd = 8'($urandom);
      nv = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_a(w, nv, nd);
      if (!nv) begin
        idle_both($urandom_range(0, 3));
        w = 8'($urandom);
      end else begin
        w = nd;
      end
    end
    idle_both(2);

    // Fast variant: one clock per bit.
    frame_b(5'b10110, 1'b0, 5'b01001);
    idle_both(2);
    wb = 5'($urandom);
    for (int k = 0; k < 6; k++) begin
      ndb = 5'($urandom);
      nv  = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      frame_b(wb, nv, ndb);
      if (!nv) begin
        idle_both($urandom_range(0, 2));
        wb = 5'($urandom);
      end else begin
        wb = ndb;
      end
    end
    idle_both(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
